if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the ARMv8 pipelined processor. Feeds the decode stage through the IF/ID register.
//  Owns the PC and drives FetchedPC, the fetch address the top-level bench polls.
//  Talks to a synchronous instruction memory (1-cycle read latency).
//  Absorbs decode stalls with a one-entry skid buffer and takes branch redirects from EX.
// PARAMETERS
//  ADDR_W   64          PC / address width
//  INSTR_W  32          instruction width
//  NOP_INSN 32'hD503201F  ARMv8 NOP, placed in if_id_instr on reset and flush
// PORTS
//  Clk           in   1        clock; all state updates on the rising edge
//  Rst           in   1        reset; asynchronous, active-low
//  startPC       in   ADDR_W   boot PC; sampled on the first edge after Rst deasserts
//  imem_req_en   out  1        instruction-memory read request this cycle
//  imem_addr     out  ADDR_W   read address; equals FetchedPC
//  imem_rdata    in   INSTR_W  read data; valid the cycle after a request
//  id_stall      in   1        decode cannot accept; hold IF/ID
//  ex_br_taken   in   1        redirect request from EX
//  ex_br_target  in   ADDR_W   redirect target
//  FetchedPC     out  ADDR_W   current fetch PC
//  if_id_valid   out  1        IF/ID holds a real instruction
//  if_id_pc      out  ADDR_W   PC of the IF/ID instruction
//  if_id_instr   out  INSTR_W  IF/ID instruction word
//  misalign_err  out  1        sticky: a redirect target had [1:0] != 0
// BEHAVIOUR
//  Reset (Rst=0, async)
//   - State = S_BOOT. FetchedPC, if_id_pc and misalign_err = 0.
//   - if_id_valid = 0, if_id_instr = NOP_INSN. Skid and F2 tracking cleared.
//   - Reset mid-operation discards in-flight reads and skid contents immediately.
//  FSM S_BOOT -> S_RUN
//   - First edge with Rst=1: PC <= startPC, go to S_RUN. imem_req_en=0 while in S_BOOT.
//  S_RUN
//   - imem_req_en = !id_stall && !ex_br_taken.
//   - On a request edge: f2_valid <= 1, f2_pc <= PC, PC <= PC+4.
//   - PC+4 is mod 2^ADDR_W, so 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
//  F2 return (cycle after a request)
//   - If !id_stall: IF/ID <= {1, f2_pc, imem_rdata}.
//   - If id_stall: data goes to the skid (skid_valid=1). IF/ID holds.
//  Stall release
//   - If skid_valid: IF/ID <= skid and skid clears. A new request issues in the same cycle.
//   - Result: exactly one bubble; no instruction is lost or duplicated.
//   - The skid never needs 2 entries because requests are suppressed during a stall.
//  IF/ID when not stalled and nothing arrives: if_id_valid <= 0.
//  Latency: first if_id_valid=1 on the 3rd rising edge after Rst deasserts (BOOT, REQ, F2).
//  Redirect (ex_br_taken=1) has priority over stall
//   - PC <= {ex_br_target[ADDR_W-1:2],2'b00}.
//   - f2_valid, skid_valid and if_id_valid cleared; if_id_instr <= NOP_INSN.
//   - misalign_err <= 1 if target[1:0] != 0; the flag stays set until reset.
//   - The next request issues the cycle after the redirect, unless stalled.
//  Redirect in S_BOOT is ignored; the boot load wins.
// STRUCTURE
//  Shared header arm_pipe_defs.vh holds:
//   - ADDR_W / INSTR_W defaults, NOP_INSN
//   - FSM state encodings S_BOOT=1'b0, S_RUN=1'b1
//  Sub-module fetch_skid_buf: one-entry {valid, pc, instr} holding register with load/drain/clear.
//  The rest (PC register, FSM, IF/ID register) lives in if_fetch_stage.
// TESTING (Clk period 60; imem model returns {addr[31:2],2'b01})
//  1 Boot: Rst=0 for 300, startPC=0x40, release
//     -> FetchedPC 0x40,0x44,0x48 on successive edges
//     -> if_id_valid first high on 3rd edge with if_id_pc=0x40
//  2 id_stall high 3 cycles with a read in flight
//     -> IF/ID frozen; skid catches one word
//     -> after release, if_id_pc sequence contiguous, no gap or duplicate
//  3 ex_br_taken=1 with target 0x100 and id_stall=1 in the same cycle
//     -> next edge FetchedPC=0x100, if_id_valid=0, if_id_instr=0xD503201F
//     -> after stall drops, next valid if_id_pc=0x100
//  4 Redirect target 0x102 -> FetchedPC=0x100, misalign_err=1
//     -> flag stays 1 through later aligned redirects
//  5 startPC=0xFFFF_FFFF_FFFF_FFFC -> FetchedPC wraps to 0x0 next fetch
//     -> if_id_pc order ...FFFC then 0x0
//  6 Rst asserted mid-cycle during stall with skid full
//     -> outputs reach reset values before the next edge
//     -> after release, boot from startPC again

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared widths, NOP encoding and FSM states for the fetch stage
package if_fetch_stage_pkg;

   localparam int          DEF_ADDR_W  = 64;
   localparam int          DEF_INSTR_W = 32;
   localparam logic [31:0] DEF_NOP_INSN = 32'hD503201F;

   typedef enum logic {
      S_BOOT = 1'b0,
      S_RUN  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {valid, pc, instr} holding register with load/drain/clear
module fetch_skid_buf #(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               load_i,
   input  logic               drain_i,
   input  logic               clear_i,
   input  logic [ADDR_W-1:0]  pc_i,
   input  logic [INSTR_W-1:0] instr_i,
   output logic               valid_o,
   output logic [ADDR_W-1:0]  pc_o,
   output logic [INSTR_W-1:0] instr_o
);

   logic               valid_q;
   logic [ADDR_W-1:0]  pc_q;
   logic [INSTR_W-1:0] instr_q;

   // clear (redirect) beats load, load beats drain
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         instr_q <= '0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         pc_q    <= pc_i;
         instr_q <= instr_i;
      end else if (drain_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
   assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - PC/FSM, synchronous imem request and IF/ID register with stall skid
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter int                 ADDR_W   = DEF_ADDR_W,
   parameter int                 INSTR_W  = DEF_INSTR_W,
   parameter logic [INSTR_W-1:0] NOP_INSN = DEF_NOP_INSN
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic [ADDR_W-1:0]  startPC,
   output logic               imem_req_en,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               id_stall,
   input  logic               ex_br_taken,
   input  logic [ADDR_W-1:0]  ex_br_target,
   output logic [ADDR_W-1:0]  FetchedPC,
   output logic               if_id_valid,
   output logic [ADDR_W-1:0]  if_id_pc,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic               misalign_err
);

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic               f2_valid_q, f2_valid_d;
   logic [ADDR_W-1:0]  f2_pc_q, f2_pc_d;
   logic               if_id_valid_q, if_id_valid_d;
   logic [ADDR_W-1:0]  if_id_pc_q, if_id_pc_d;
   logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
   logic               misalign_q, misalign_d;

   logic               skid_load, skid_drain, skid_clear;
   logic               skid_valid;
   logic [ADDR_W-1:0]  skid_pc;
   logic [INSTR_W-1:0] skid_instr;

   fetch_skid_buf #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_skid (
      .clk_i   (Clk),
      .rst_ni  (Rst),
      .load_i  (skid_load),
      .drain_i (skid_drain),
      .clear_i (skid_clear),
      .pc_i    (f2_pc_q),
      .instr_i (imem_rdata),
      .valid_o (skid_valid),
      .pc_o    (skid_pc),
      .instr_o (skid_instr)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      f2_valid_d    = 1'b0;
      f2_pc_d       = f2_pc_q;
      if_id_valid_d = if_id_valid_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_instr_d = if_id_instr_q;
      misalign_d    = misalign_q;
      skid_load     = 1'b0;
      skid_drain    = 1'b0;
      skid_clear    = 1'b0;
      imem_req_en   = 1'b0;

      case (state_q)
         S_BOOT: begin
            pc_d    = startPC;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (ex_br_taken) begin
               pc_d          = {ex_br_target[ADDR_W-1:2], 2'b00};
               skid_clear    = 1'b1;
               if_id_valid_d = 1'b0;
               if_id_instr_d = NOP_INSN;
               if (ex_br_target[1:0] != 2'b00) misalign_d = 1'b1;
            end else begin
               imem_req_en = !id_stall;
               if (imem_req_en) begin
                  f2_valid_d = 1'b1;
                  f2_pc_d    = pc_q;
                  pc_d       = pc_q + ADDR_W'(4);
               end
               // requests stop while stalled, so at most one word ever needs parking
               if (id_stall) begin
                  if (f2_valid_q) skid_load = 1'b1;
               end else if (skid_valid) begin
                  if_id_valid_d = 1'b1;
                  if_id_pc_d    = skid_pc;
                  if_id_instr_d = skid_instr;
                  skid_drain    = 1'b1;
               end else if (f2_valid_q) begin
                  if_id_valid_d = 1'b1;
                  if_id_pc_d    = f2_pc_q;
                  if_id_instr_d = imem_rdata;
               end else begin
                  if_id_valid_d = 1'b0;
               end
            end
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q       <= S_BOOT;
         pc_q          <= '0;
         f2_valid_q    <= 1'b0;
         f2_pc_q       <= '0;
         if_id_valid_q <= 1'b0;
         if_id_pc_q    <= '0;
         if_id_instr_q <= NOP_INSN;
         misalign_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         f2_valid_q    <= f2_valid_d;
         f2_pc_q       <= f2_pc_d;
         if_id_valid_q <= if_id_valid_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_instr_q <= if_id_instr_d;
         misalign_q    <= misalign_d;
      end
   end

   assign imem_addr    = pc_q;
   assign FetchedPC    = pc_q;
   assign if_id_valid  = if_id_valid_q;
   assign if_id_pc     = if_id_pc_q;
   assign if_id_instr  = if_id_instr_q;
   assign misalign_err = misalign_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'hD503201F;

   logic        Clk;
   logic        Rst;
   logic [63:0] startPC;
   logic        imem_req_en;
   logic [63:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        id_stall;
   logic        ex_br_taken;
   logic [63:0] ex_br_target;
   logic [63:0] FetchedPC;
   logic        if_id_valid;
   logic [63:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        misalign_err;

   int n_checks = 0;
   int n_fail   = 0;

   if_fetch_stage dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .startPC      (startPC),
      .imem_req_en  (imem_req_en),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .id_stall     (id_stall),
      .ex_br_taken  (ex_br_taken),
      .ex_br_target (ex_br_target),
      .FetchedPC    (FetchedPC),
      .if_id_valid  (if_id_valid),
      .if_id_pc     (if_id_pc),
      .if_id_instr  (if_id_instr),
      .misalign_err (misalign_err)
   );

   initial Clk = 1'b0;
   always #30 Clk = ~Clk;

   // synchronous imem: word returned the cycle after the request
   always @(posedge Clk) begin
      if (imem_req_en) imem_rdata <= {imem_addr[31:2], 2'b01};
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check_ifid(input string tag, input logic v, input logic [63:0] pc, input logic [31:0] ins);
      check_eq({tag, ".valid"}, {63'd0, if_id_valid}, {63'd0, v});
      check_eq({tag, ".pc"}, if_id_pc, pc);
      check_eq({tag, ".instr"}, {32'd0, if_id_instr}, {32'd0, ins});
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, ".FetchedPC"}, FetchedPC, 64'h0);
      check_eq({tag, ".req"}, {63'd0, imem_req_en}, 64'h0);
      check_eq({tag, ".misalign"}, {63'd0, misalign_err}, 64'h0);
      check_ifid(tag, 1'b0, 64'h0, NOP);
   endtask

   initial begin
      Rst          = 1'b0;
      startPC      = 64'h40;
      id_stall     = 1'b0;
      ex_br_taken  = 1'b0;
      ex_br_target = 64'h0;
      imem_rdata   = 32'h0;

      // 1: boot
      #300;
      check_reset_vals("rst");
      Rst = 1'b1;
      tick();
      check_eq("boot.e1.pc", FetchedPC, 64'h40);
      check_eq("boot.e1.valid", {63'd0, if_id_valid}, 64'h0);
      tick();
      check_eq("boot.e2.pc", FetchedPC, 64'h44);
      check_eq("boot.e2.valid", {63'd0, if_id_valid}, 64'h0);
      tick();
      check_eq("boot.e3.pc", FetchedPC, 64'h48);
      check_ifid("boot.e3", 1'b1, 64'h40, 32'h41);
      tick();
      check_ifid("boot.e4", 1'b1, 64'h44, 32'h45);
      check_eq("boot.e4.pc", FetchedPC, 64'h4C);

      // 2: stall three cycles with 0x48 in flight
      id_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_ifid("stall.hold", 1'b1, 64'h44, 32'h45);
         check_eq("stall.pc", FetchedPC, 64'h4C);
         check_eq("stall.req", {63'd0, imem_req_en}, 64'h0);
      end
      id_stall = 1'b0;
      tick();
      check_ifid("rel.skid", 1'b1, 64'h48, 32'h49);
      tick();
      check_ifid("rel.n1", 1'b1, 64'h4C, 32'h4D);
      tick();
      check_ifid("rel.n2", 1'b1, 64'h50, 32'h51);
      check_eq("rel.pc", FetchedPC, 64'h58);

      // 3: redirect together with stall
      ex_br_taken  = 1'b1;
      ex_br_target = 64'h100;
      id_stall     = 1'b1;
      #1;
      check_eq("br.req", {63'd0, imem_req_en}, 64'h0);
      tick();
      check_eq("br.pc", FetchedPC, 64'h100);
      check_eq("br.valid", {63'd0, if_id_valid}, 64'h0);
      check_eq("br.instr", {32'd0, if_id_instr}, {32'd0, NOP});
      ex_br_taken = 1'b0;
      tick();
      check_eq("br.stall.pc", FetchedPC, 64'h100);
      check_eq("br.stall.valid", {63'd0, if_id_valid}, 64'h0);
      id_stall = 1'b0;
      tick();
      check_eq("br.req.pc", FetchedPC, 64'h104);
      check_eq("br.req.valid", {63'd0, if_id_valid}, 64'h0);
      tick();
      check_ifid("br.first", 1'b1, 64'h100, 32'h101);
      check_eq("br.misalign", {63'd0, misalign_err}, 64'h0);

      // 4: misaligned target, then an aligned one
      ex_br_taken  = 1'b1;
      ex_br_target = 64'h102;
      tick();
      check_eq("mis.pc", FetchedPC, 64'h100);
      check_eq("mis.flag", {63'd0, misalign_err}, 64'h1);
      check_eq("mis.valid", {63'd0, if_id_valid}, 64'h0);
      ex_br_target = 64'h200;
      tick();
      check_eq("mis2.pc", FetchedPC, 64'h200);
      check_eq("mis2.flag", {63'd0, misalign_err}, 64'h1);
      ex_br_taken = 1'b0;
      tick();
      check_eq("mis3.pc", FetchedPC, 64'h204);
      check_eq("mis3.flag", {63'd0, misalign_err}, 64'h1);

      // 5: PC wrap from the top of the address space
      Rst     = 1'b0;
      startPC = 64'hFFFF_FFFF_FFFF_FFFC;
      #1;
      check_eq("wrap.rst.flag", {63'd0, misalign_err}, 64'h0);
      @(negedge Clk);
      Rst = 1'b1;
      tick();
      check_eq("wrap.e1.pc", FetchedPC, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      check_eq("wrap.e2.pc", FetchedPC, 64'h0);
      tick();
      check_eq("wrap.e3.pc", FetchedPC, 64'h4);
      check_ifid("wrap.e3", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFD);
      tick();
      check_ifid("wrap.e4", 1'b1, 64'h0, 32'h1);

      // 6: async reset while stalled with the skid full
      id_stall = 1'b1;
      tick();
      check_ifid("rs.hold", 1'b1, 64'h0, 32'h1);
      @(negedge Clk);
      Rst     = 1'b0;
      startPC = 64'h40;
      #1;
      check_reset_vals("rs.async");
      @(negedge Clk);
      Rst      = 1'b1;
      id_stall = 1'b0;
      tick();
      check_eq("rs.e1.pc", FetchedPC, 64'h40);
      check_eq("rs.e1.valid", {63'd0, if_id_valid}, 64'h0);
      tick();
      check_eq("rs.e2.valid", {63'd0, if_id_valid}, 64'h0);
      tick();
      check_ifid("rs.e3", 1'b1, 64'h40, 32'h41);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
